// File: rtl/pipe_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data load/store.
// One access in flight at a time, one-cycle acks, combinational stall, watchdog abort on hung accesses.
module pipe_mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            dm_rd,
  input  logic            dm_wr,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ack,
  output logic            stall,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);

  localparam int BEW = DW / 8;
  localparam int BCW = $clog2(MAX_DATA_BURST + 1);
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t         state, state_nx;
  logic [BCW-1:0] burst_cnt;
  logic [WCW-1:0] wd_cnt;
  logic           dm_any;
  logic           burst_full;
  logic           grant_fetch, grant_data;
  logic           timeout;
  logic           done;

  assign dm_any     = dm_rd | dm_wr;
  assign burst_full = (burst_cnt == BCW'(MAX_DATA_BURST));
  assign timeout    = (TIMEOUT != 0) && (state != IDLE) && !mem_ready &&
                      (wd_cnt == WCW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge Rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!Rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and grant decision; the ack cycle never re-arbitrates the still-held request.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_nx    = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    case (state)
      IDLE: begin
        if (!if_ack && !dm_ack) begin
          if (dm_any && !(burst_full && if_req)) begin
            grant_data = 1'b1;
            state_nx   = DATA;
          end else if (if_req) begin
            grant_fetch = 1'b1;
            state_nx    = FETCH;
          end
        end
      end
      FETCH, DATA: if (mem_ready || timeout) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    done  = (state != IDLE) && (mem_ready || timeout);
    stall = Rst & ((if_req & ~if_ack) | (dm_any & ~dm_ack));
  end

  // Memory-side registers, acks, returned data and counters
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      burst_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      bus_err <= 1'b0;

      if (grant_data) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_wr;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_wr ? dm_be : {BEW{1'b1}};
        wd_cnt    <= '0;
        if (!burst_full) burst_cnt <= burst_cnt + BCW'(1);
      end else if (grant_fetch) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_be    <= {BEW{1'b1}};
        wd_cnt    <= '0;
        burst_cnt <= '0;
      end else if (done) begin
        mem_req <= 1'b0;
        bus_err <= timeout;
        if (state == FETCH) begin
          if_ack   <= 1'b1;
          if_rdata <= timeout ? '0 : mem_rdata;
        end else begin
          dm_ack <= 1'b1;
          if (!mem_we) dm_rdata <= timeout ? '0 : mem_rdata;
        end
      end else if ((state != IDLE) && (TIMEOUT != 0)) begin
        wd_cnt <= wd_cnt + WCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Randomized scoreboard bench for pipe_mem_arbiter: drivers push expected responses,
// a monitor checks grants, acks, latency and stall against them.
module tb_pipe_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXB = 4, TMO = 16, BEW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, if_ack, dm_rd, dm_wr, dm_ack, stall, bus_err;
  logic            mem_req, mem_we, mem_ready;
  logic [AW-1:0]   if_addr, dm_addr, mem_addr;
  logic [DW-1:0]   if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic [BEW-1:0]  dm_be, mem_be;

  pipe_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .Rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  addr;
    logic           we;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rdata;
    logic           err;
  } exp_t;

  typedef struct {
    logic           rd;
    logic           wr;
    logic [3:0]     idx;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] be;
  } dcmd_t;

  exp_t          if_sb[$], dm_sb[$];
  logic [AW-1:0] fcmd[$];
  dcmd_t         dcmd[$];
  logic [DW-1:0] dm_model[16];
  logic [DW-1:0] mem_data[16];
  logic [DW-1:0] last_read = '0;
  int            checks = 0, errors = 0;
  int            cyc = 0, grant_cnt = 0, cur_delay = 0, delay_mode = 1;
  bit            hang = 1'b0, f_busy = 1'b0, d_busy = 1'b0, prev_req = 1'b0;
  string         grant_log = "";

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return a ^ 32'h2002_0000;
  endfunction

  function automatic logic [AW-1:0] daddr(input logic [3:0] i);
    return 32'h8000_0000 | {26'd0, i, 2'b00};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory device: answers each access after a chosen delay, or never while hang is set
  initial begin : responder
    bit busy = 1'b0;
    int wcnt = 0;
    logic [3:0] idx;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        busy = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          cur_delay = hang ? 100000 : (delay_mode == 0 ? 0 : int'($urandom_range(3, 0)));
        end
        if (wcnt == cur_delay) begin
          mem_ready = 1'b1;
          if (!mem_addr[AW-1]) mem_rdata = rom(mem_addr);
          else begin
            idx = mem_addr[5:2];
            if (mem_we) begin
              for (int b = 0; b < BEW; b++)
                if (mem_be[b]) mem_data[idx][8*b +: 8] = mem_wdata[8*b +: 8];
              mem_rdata = $urandom;
            end else mem_rdata = mem_data[idx];
          end
        end else wcnt++;
      end else busy = 1'b0;
    end
  end

  // Fetch driver: holds if_req until if_ack, back-to-back when more commands are queued
  initial begin : fetch_drv
    int   wait_n = 0;
    exp_t e;
    if_req = 1'b0;
    if_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if_req = 1'b0; fcmd.delete(); f_busy = 1'b0;
        continue;
      end
      if (f_busy) begin
        if (if_ack) f_busy = 1'b0;
        else if (++wait_n > 400) begin
          fail_now("fetch_ack_timeout");
          f_busy = 1'b0;
        end
      end
      if (!f_busy) begin
        if (fcmd.size() > 0) begin
          if_addr = fcmd.pop_front();
          if_req  = 1'b1;
          e.addr = if_addr; e.we = 1'b0; e.be = '1; e.wdata = '0;
          e.rdata = hang ? '0 : rom(if_addr);
          e.err = hang;
          if_sb.push_back(e);
          f_busy = 1'b1;
          wait_n = 0;
        end else if_req = 1'b0;
      end
    end
  end

  // Data driver: the expected load value comes from a word array updated at each store
  initial begin : data_drv
    int    wait_n = 0;
    exp_t  e;
    dcmd_t c;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        dm_rd = 1'b0; dm_wr = 1'b0; dcmd.delete(); d_busy = 1'b0;
        continue;
      end
      if (d_busy) begin
        if (dm_ack) d_busy = 1'b0;
        else if (++wait_n > 400) begin
          fail_now("data_ack_timeout");
          d_busy = 1'b0;
        end
      end
      if (!d_busy) begin
        if (dcmd.size() > 0) begin
          c = dcmd.pop_front();
          dm_rd = c.rd; dm_wr = c.wr; dm_addr = daddr(c.idx); dm_wdata = c.wdata; dm_be = c.be;
          e.addr = daddr(c.idx); e.we = c.wr; e.be = c.wr ? c.be : '1; e.wdata = c.wdata;
          e.err = hang;
          if (c.wr) begin
            for (int b = 0; b < BEW; b++)
              if (c.be[b]) dm_model[c.idx][8*b +: 8] = c.wdata[8*b +: 8];
            e.rdata = last_read;
          end else begin
            e.rdata = hang ? '0 : dm_model[c.idx];
            last_read = e.rdata;
          end
          dm_sb.push_back(e);
          d_busy = 1'b1;
          wait_n = 0;
        end else begin
          dm_rd = 1'b0; dm_wr = 1'b0;
        end
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge
  initial begin : monitor
    int   rise_cyc = 0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      check("stall", {31'd0, stall},
            {31'd0, rst & ((if_req & ~if_ack) | ((dm_rd | dm_wr) & ~dm_ack))});
      if (mem_req && !prev_req) begin
        grant_cnt++;
        rise_cyc = cyc;
        if (!mem_addr[AW-1]) begin
          grant_log = {grant_log, "F"};
          if (if_sb.size() == 0) fail_now("unexpected_fetch_grant");
          else begin
            e = if_sb[0];
            check("fetch_mem_addr", mem_addr, e.addr);
            check("fetch_mem_we", {31'd0, mem_we}, 32'd0);
            check("fetch_mem_be", {28'd0, mem_be}, {28'd0, e.be});
          end
        end else begin
          grant_log = {grant_log, "D"};
          if (dm_sb.size() == 0) fail_now("unexpected_data_grant");
          else begin
            e = dm_sb[0];
            check("data_mem_addr", mem_addr, e.addr);
            check("data_mem_we", {31'd0, mem_we}, {31'd0, e.we});
            check("data_mem_be", {28'd0, mem_be}, {28'd0, e.be});
            if (e.we) check("data_mem_wdata", mem_wdata, e.wdata);
          end
        end
      end
      prev_req = mem_req;
      if (if_ack) begin
        if (if_sb.size() == 0) fail_now("unexpected_if_ack");
        else begin
          e = if_sb.pop_front();
          check("if_rdata", if_rdata, e.rdata);
          check("if_bus_err", {31'd0, bus_err}, {31'd0, e.err});
          check("if_latency", 32'(cyc - rise_cyc), 32'(e.err ? TMO : cur_delay + 1));
        end
      end
      if (dm_ack) begin
        if (dm_sb.size() == 0) fail_now("unexpected_dm_ack");
        else begin
          e = dm_sb.pop_front();
          check("dm_rdata", dm_rdata, e.rdata);
          check("dm_bus_err", {31'd0, bus_err}, {31'd0, e.err});
          check("dm_latency", 32'(cyc - rise_cyc), 32'(e.err ? TMO : cur_delay + 1));
        end
      end
      if (bus_err && !if_ack && !dm_ack) fail_now("bus_err_without_ack");
    end
  end

  initial begin : time_limit
    #500000;
    $display("FAIL global_time_limit at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    if_sb.delete(); dm_sb.delete();
    hang = 1'b0;
    last_read = '0;
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((fcmd.size() > 0 || dcmd.size() > 0 || f_busy || d_busy ||
            if_sb.size() > 0 || dm_sb.size() > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) fail_now({name, "_drain_timeout"});
    repeat (3) @(posedge clk);
  endtask

  task automatic push_data(input bit rd, input bit wr, input logic [3:0] idx,
                           input logic [DW-1:0] wdata, input logic [BEW-1:0] be);
    dcmd_t c;
    c.rd = rd; c.wr = wr; c.idx = idx; c.wdata = wdata; c.be = be;
    dcmd.push_back(c);
  endtask

  initial begin : main
    int g0, n;
    string exp_log;
    for (int i = 0; i < 16; i++) begin
      dm_model[i] = 32'h1000_0000 + 32'(i) * 32'h0111_0111;
      mem_data[i] = dm_model[i];
    end
    rst = 1'b0;
    repeat (3) @(posedge clk); #2;
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_if_ack", {31'd0, if_ack}, 32'd0);
    check("reset_dm_ack", {31'd0, dm_ack}, 32'd0);
    check("reset_bus_err", {31'd0, bus_err}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_be", {28'd0, mem_be}, 32'd0);
    check("reset_if_rdata", if_rdata, 32'd0);
    check("reset_dm_rdata", dm_rdata, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #2;

    // Single fetch with zero-wait memory
    delay_mode = 0;
    fcmd.push_back(32'h0000_0005);
    drain("fetch_only");

    // Fetch starvation bound: four data grants, then the pending fetch
    do_reset();
    grant_log = "";
    fcmd.push_back(32'h0000_0100);
    fcmd.push_back(32'h0000_0104);
    for (int i = 0; i < 8; i++) push_data(1'b1, 1'b0, 4'(i), '0, '0);
    drain("burst");
    exp_log = "DDDDFDDDDF";
    checks++;
    if (grant_log != exp_log) begin
      errors++;
      $display("FAIL burst_grant_order: got %s expected %s", grant_log, exp_log);
    end

    // Read, partial store, store with rd+wr both high, read back
    push_data(1'b1, 1'b0, 4'd3, '0, '0);
    push_data(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'b0011);
    push_data(1'b1, 1'b1, 4'd5, 32'hCAFE_F00D, 4'b1100);
    push_data(1'b1, 1'b0, 4'd3, '0, '0);
    push_data(1'b1, 1'b0, 4'd5, '0, '0);
    drain("store");

    // Watchdog abort on a hung fetch and a hung load, then normal service
    hang = 1'b1;
    fcmd.push_back(32'h0000_0200);
    drain("timeout_fetch");
    push_data(1'b1, 1'b0, 4'd7, '0, '0);
    drain("timeout_load");
    hang = 1'b0;
    fcmd.push_back(32'h0000_0204);
    push_data(1'b1, 1'b0, 4'd7, '0, '0);
    drain("after_timeout");

    // Reset in the middle of a fetch
    hang = 1'b1;
    fcmd.push_back(32'h0000_0040);
    n = 0;
    while (!mem_req && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) fail_now("mid_fetch_no_grant");
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_async_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_async_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    if_sb.delete();
    hang = 1'b0;
    last_read = '0;
    g0 = grant_cnt;
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    check("no_grant_after_reset", 32'(grant_cnt), 32'(g0));
    fcmd.push_back(32'h0000_0044);
    drain("after_reset");

    // Back-to-back fetches with if_req held through each ack
    g0 = grant_cnt;
    for (int i = 0; i < 4; i++) fcmd.push_back(32'h0000_0300);
    drain("back_to_back");
    repeat (4) @(posedge clk);
    check("one_grant_per_ack", 32'(grant_cnt - g0), 32'd4);

    // Randomized concurrent traffic with random memory wait states
    delay_mode = 1;
    for (int i = 0; i < 60; i++) begin
      int r;
      fcmd.push_back($urandom & 32'h7FFF_FFFC);
      r = int'($urandom_range(2, 0));
      push_data(r != 1, r != 0, 4'($urandom_range(15, 0)), $urandom, 4'($urandom));
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
